// File: rtl/boot_ctrl_if.sv
// Loader byte stream, imem write port, hart control and status of boot_ctrl.
// The controller connects via the slave modport; its environment uses master.
interface boot_ctrl_if;
    logic        i_load_valid;
    logic [7:0]  i_load_data;
    logic        i_load_last;
    logic        o_load_ready;
    logic        o_imem_wen;
    logic [31:0] o_imem_waddr;
    logic [31:0] o_imem_wdata;
    logic [3:0]  o_imem_wmask;
    logic        o_hart_rst;
    logic        i_retire_valid;
    logic        i_retire_halt;
    logic        i_restart;
    logic        o_done;
    logic        o_overflow;
    logic [31:0] o_cycles;
    logic [31:0] o_retired;

    modport slave (
        input  i_load_valid, i_load_data, i_load_last, i_retire_valid, i_retire_halt, i_restart,
        output o_load_ready, o_imem_wen, o_imem_waddr, o_imem_wdata, o_imem_wmask,
               o_hart_rst, o_done, o_overflow, o_cycles, o_retired
    );

    modport master (
        output i_load_valid, i_load_data, i_load_last, i_retire_valid, i_retire_halt, i_restart,
        input  o_load_ready, o_imem_wen, o_imem_waddr, o_imem_wdata, o_imem_wmask,
               o_hart_rst, o_done, o_overflow, o_cycles, o_retired
    );
endinterface

// File: rtl/boot_ctrl.sv
// Boot controller: packs a byte stream into imem words, holds the hart in reset,
// then runs it while counting cycles and retired instructions until it halts.
module boot_ctrl #(
    parameter logic [31:0] RESET_ADDR = 32'h0,
    parameter int          MAX_BYTES  = 1024,
    parameter int          RST_HOLD   = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    boot_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {LOAD, FLUSH, HOLD, RUN, HALTED} state_t;

    state_t      state;
    logic [31:0] byte_cnt;
    logic [29:0] word_idx;
    logic [31:0] word;
    logic [7:0]  hold_cnt;
    logic        wen;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        hart_rst;
    logic        done;
    logic        overflow;
    logic [31:0] cycles;
    logic [31:0] retired;

    logic [1:0]  k;
    logic        last;
    logic [31:0] word_nxt;

    assign k    = byte_cnt[1:0];
    // Byte number MAX_BYTES closes the stream even without i_load_last.
    assign last = bus.i_load_last || (byte_cnt == 32'(MAX_BYTES - 1));

    always_comb begin
        word_nxt = word;
        word_nxt[{k, 3'b000} +: 8] = bus.i_load_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= LOAD;
            byte_cnt <= '0;
            word_idx <= '0;
            word     <= '0;
            hold_cnt <= '0;
            wen      <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            wmask    <= '0;
            hart_rst <= 1'b1;
            done     <= 1'b0;
            overflow <= 1'b0;
            cycles   <= '0;
            retired  <= '0;
        end else begin
            wen <= 1'b0;
            case (state)
                LOAD: if (bus.i_load_valid) begin
                    byte_cnt <= byte_cnt + 32'd1;
                    if (k == 2'd3 || last) begin
                        wen      <= 1'b1;
                        waddr    <= RESET_ADDR + {word_idx, 2'b00};
                        wdata    <= word_nxt;
                        wmask    <= 4'b1111 >> (2'd3 - k);
                        word     <= '0;
                        word_idx <= word_idx + 30'd1;
                    end else begin
                        word <= word_nxt;
                    end
                    if (last) begin
                        state <= FLUSH;
                        if (!bus.i_load_last) overflow <= 1'b1;
                    end
                end
                FLUSH: begin
                    state    <= HOLD;
                    hold_cnt <= '0;
                end
                HOLD: begin
                    if (hold_cnt == 8'(RST_HOLD - 1)) begin
                        state    <= RUN;
                        hart_rst <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                RUN: begin
                    // The halting cycle itself is still counted.
                    cycles <= cycles + 32'd1;
                    if (bus.i_retire_valid) retired <= retired + 32'd1;
                    if (bus.i_retire_halt) begin
                        state    <= HALTED;
                        done     <= 1'b1;
                        hart_rst <= 1'b1;
                    end
                end
                HALTED: if (bus.i_restart) begin
                    state    <= HOLD;
                    hold_cnt <= '0;
                    done     <= 1'b0;
                    cycles   <= '0;
                    retired  <= '0;
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign bus.o_load_ready = (state == LOAD);
    assign bus.o_imem_wen   = wen;
    assign bus.o_imem_waddr = waddr;
    assign bus.o_imem_wdata = wdata;
    assign bus.o_imem_wmask = wmask;
    assign bus.o_hart_rst   = hart_rst;
    assign bus.o_done       = done;
    assign bus.o_overflow   = overflow;
    assign bus.o_cycles     = cycles;
    assign bus.o_retired    = retired;
endmodule

// File: tb/tb_boot_ctrl.sv
// Directed bench for boot_ctrl: expected imem writes go into a queue that a
// negedge monitor drains; status outputs are checked inline.
module tb_boot_ctrl;
    localparam logic [31:0] RA = 32'h0000_0100;
    localparam int          MB = 8;
    localparam int          RH = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    boot_ctrl_if bus();
    boot_ctrl #(.RESET_ADDR(RA), .MAX_BYTES(MB), .RST_HOLD(RH)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        wr_t e;
        e.addr = a; e.data = d; e.mask = m;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        if (bus.o_imem_wen === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr %h data %h mask %b expected no write",
                         bus.o_imem_waddr, bus.o_imem_wdata, bus.o_imem_wmask);
            end else begin
                e = exp_q.pop_front();
                if (bus.o_imem_waddr !== e.addr || bus.o_imem_wdata !== e.data || bus.o_imem_wmask !== e.mask) begin
                    n_bad++;
                    $display("FAIL imem_write: got addr %h data %h mask %b expected addr %h data %h mask %b",
                             bus.o_imem_waddr, bus.o_imem_wdata, bus.o_imem_wmask, e.addr, e.data, e.mask);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        bus.i_load_valid = 1'b1; bus.i_load_data = d; bus.i_load_last = l;
        while (bus.o_load_ready !== 1'b1 && n < 20) begin
            @(negedge clk); n++;
        end
        if (n >= 20) check("load_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 bus.i_load_valid = 1'b0; bus.i_load_last = 1'b0;
    endtask

    // Counts negedges until hart reset drops (bounded).
    task automatic wait_run(output int n);
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (bus.o_hart_rst !== 1'b0 && n < 50);
    endtask

    initial begin
        int n;
        logic [7:0] prog8 [8];
        prog8 = '{8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h00, 8'h00};
        bus.i_load_valid = 1'b0; bus.i_load_data = '0; bus.i_load_last = 1'b0;
        bus.i_retire_valid = 1'b0; bus.i_retire_halt = 1'b0; bus.i_restart = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready",    {31'd0, bus.o_load_ready}, 32'd1);
        check("rst_hart_rst", {31'd0, bus.o_hart_rst},   32'd1);
        check("rst_done",     {31'd0, bus.o_done},       32'd0);
        check("rst_overflow", {31'd0, bus.o_overflow},   32'd0);
        check("rst_cycles",   bus.o_cycles,              32'd0);
        check("rst_retired",  bus.o_retired,             32'd0);
        rst = 1'b0;

        // Reset mid-load discards the partial word; next stream starts at RA
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0);
        do_reset();
        check("midload_rst_ready", {31'd0, bus.o_load_ready}, 32'd1);
        expect_wr(RA, 32'h4433_2211, 4'b1111);
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b1);
        repeat (3) @(negedge clk);

        // Two-word program, hart release timing, run and halt
        do_reset();
        expect_wr(RA,      32'h0000_0093, 4'b1111);
        expect_wr(RA + 4,  32'h0000_0113, 4'b1111);
        for (int i = 0; i < 8; i++) send_byte(prog8[i], i == 7);
        wait_run(n);
        check("release_delay", n, RH + 2);
        check("no_overflow", {31'd0, bus.o_overflow}, 32'd0);
        check("run_cycles0", bus.o_cycles, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            bus.i_retire_valid = 1'b1; bus.i_retire_halt = (i == 5);
            @(negedge clk);
        end
        bus.i_retire_halt = 1'b0;
        check("halt_done",    {31'd0, bus.o_done}, 32'd1);
        check("halt_cycles",  bus.o_cycles,        32'd5);
        check("halt_retired", bus.o_retired,       32'd5);
        repeat (10) @(negedge clk);
        bus.i_retire_valid = 1'b0;
        check("frozen_cycles",  bus.o_cycles,              32'd5);
        check("frozen_retired", bus.o_retired,             32'd5);
        check("frozen_done",    {31'd0, bus.o_done},       32'd1);
        check("halted_hart_rst", {31'd0, bus.o_hart_rst},  32'd1);

        // Restart from HALTED
        bus.i_restart = 1'b1;
        @(posedge clk); #1 bus.i_restart = 1'b0;
        @(negedge clk);
        check("restart_cycles",  bus.o_cycles,             32'd0);
        check("restart_retired", bus.o_retired,            32'd0);
        check("restart_done",    {31'd0, bus.o_done},      32'd0);
        check("restart_hart_rst", {31'd0, bus.o_hart_rst}, 32'd1);
        wait_run(n);
        check("restart_hold", n, RH);
        bus.i_restart = 1'b1;
        @(negedge clk);
        bus.i_restart = 1'b0;
        check("restart_ignored_run", {31'd0, bus.o_hart_rst}, 32'd0);
        check("run_cycles1", bus.o_cycles, 32'd1);

        // Partial last word
        do_reset();
        expect_wr(RA,     32'h0403_0201, 4'b1111);
        expect_wr(RA + 4, 32'h0000_0605, 4'b0011);
        for (int i = 1; i <= 6; i++) send_byte(8'(i), i == 6);
        repeat (3) @(negedge clk);

        // One-byte program
        do_reset();
        expect_wr(RA, 32'h0000_0037, 4'b0001);
        send_byte(8'h37, 1'b1);
        repeat (3) @(negedge clk);

        // Overflow at MAX_BYTES, ignored retire inputs outside RUN, reset mid-RUN
        do_reset();
        expect_wr(RA,     32'h0403_0201, 4'b1111);
        expect_wr(RA + 4, 32'h0807_0605, 4'b1111);
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
        bus.i_load_valid = 1'b1; bus.i_load_data = 8'h09;
        bus.i_retire_valid = 1'b1; bus.i_retire_halt = 1'b1;
        wait_run(n);
        bus.i_load_valid = 1'b0; bus.i_retire_valid = 1'b0; bus.i_retire_halt = 1'b0;
        check("ovf_release_delay", n, RH + 2);
        check("ovf_flag",     {31'd0, bus.o_overflow},   32'd1);
        check("ovf_ready",    {31'd0, bus.o_load_ready}, 32'd0);
        check("ovf_retired",  bus.o_retired,             32'd0);
        check("ovf_done",     {31'd0, bus.o_done},       32'd0);
        @(negedge clk);
        check("ovf_run_cycles", bus.o_cycles, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("runrst_hart_rst", {31'd0, bus.o_hart_rst}, 32'd1);
        check("runrst_cycles",   bus.o_cycles,            32'd0);
        check("runrst_overflow", {31'd0, bus.o_overflow}, 32'd0);
        check("runrst_ready",    {31'd0, bus.o_load_ready}, 32'd1);
        repeat (2) @(negedge clk);

        check("pending_writes", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/boot_ctrl.md
BOOT_CTRL -- requirements
Module: boot_ctrl

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0, sets the imem byte address where the first loaded byte is written.
REQ-002 Parameter MAX_BYTES, default 1024, sets the imem capacity in bytes; it is a multiple of 4.
REQ-003 Parameter RST_HOLD, default 2, sets the number of cycles the hart reset is held after a load, range 1..255.
REQ-004 i_clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 i_rst  in  1  reset, synchronous and active-high.
REQ-006 i_load_valid  in  1  a program byte is offered.
REQ-007 i_load_data  in  8  the program byte, in little-endian stream order.
REQ-008 i_load_last  in  1  qualifies the final byte of the stream.
REQ-009 o_load_ready  out  1  a byte is accepted when i_load_valid & o_load_ready.
REQ-010 o_imem_wen, o_imem_waddr[31:0], o_imem_wdata[31:0], o_imem_wmask[3:0]  out  the imem word write port.
REQ-011 o_hart_rst  out  1  drives the hart i_rst.
REQ-012 i_retire_valid, i_retire_halt  in  1 each  the hart retire strobes.
REQ-013 i_restart  in  1  re-run the loaded program without reloading it.
REQ-014 o_done  out  1  the program has halted.
REQ-015 o_overflow  out  1  sticky flag: the stream was truncated at MAX_BYTES.
REQ-016 o_cycles, o_retired  out  32 each  run-cycle count and retired-instruction count.

Function
REQ-017 The state machine SHALL have exactly the states LOAD, FLUSH, HOLD, RUN and HALTED.
REQ-018 In LOAD, o_load_ready=1; in all other states, o_load_ready=0.
REQ-019 Accepted bytes SHALL be packed into a word, with byte k at bits [8k+7:8k], where k = byte_cnt[1:0].
REQ-020 The write trigger is acceptance of a byte with k=3, or of a byte with i_load_last=1; on the next cycle o_imem_wen=1 for exactly 1 cycle, with waddr = RESET_ADDR + 4*word_index.
REQ-021 The write mask SHALL be 4'b1111 for a full word, and the low k+1 bits set for a partial last word; unwritten data bytes are 0.
REQ-022 When the accepted byte is number MAX_BYTES and i_load_last=0, it SHALL be treated as last and o_overflow set to 1.
REQ-023 On the last byte, LOAD->FLUSH; FLUSH issues the final write and then -> HOLD on the next cycle.
REQ-024 An accepted last byte of a zero-offset stream (a 1-byte program) SHALL produce mask 4'b0001.
REQ-025 o_hart_rst=1 in LOAD, FLUSH and HOLD; HOLD lasts exactly RST_HOLD cycles, then -> RUN.
REQ-026 In RUN, o_hart_rst=0; o_cycles increments every RUN cycle; o_retired increments on each cycle with i_retire_valid=1.
REQ-027 i_retire_halt=1 in RUN SHALL move to HALTED on the next edge; that cycle is still counted, including its retire.
REQ-028 In HALTED: o_done=1, o_hart_rst=1, and the counters are frozen.
REQ-029 i_restart in HALTED SHALL clear the counters and o_done and go to HOLD; i_restart in any other state is ignored.
REQ-030 Counters SHALL wrap modulo 2^32.
REQ-031 i_retire_valid and i_retire_halt SHALL be ignored outside RUN.

Reset
REQ-032 i_rst=1 SHALL, on the next edge, set: state=LOAD, byte/word counters=0, partial word=0, o_imem_wen=0, o_hart_rst=1, o_load_ready=1 (after the edge), o_done=0, o_overflow=0, o_cycles=0, o_retired=0.
REQ-033 Reset mid-load SHALL discard the partial word and issue no write; reset mid-RUN SHALL reassert o_hart_rst on the next edge.
REQ-034 i_rst has priority over every other input in the same cycle.

Verification
REQ-035 Stream bytes 93 00 00 00 13 01 00 00 (last on 8th) -> two writes: addr 0 data 00000093 mask 1111; addr 4 data 00000113 mask 1111; o_hart_rst low exactly RST_HOLD+2 cycles after the last accept.
REQ-036 Stream of 6 bytes 01..06 (last on 6th) -> writes: addr 0 data 04030201 mask 1111; addr 4 data 00000605 mask 0011.
REQ-037 MAX_BYTES=8 with a 10-byte stream and no last -> exactly 2 writes, o_overflow=1, o_load_ready=0 after the 8th byte.
REQ-038 RUN for 5 cycles with i_retire_valid every cycle and halt on the 5th -> o_done=1, o_cycles=5, o_retired=5, both stable for 10 more cycles.
REQ-039 i_restart in HALTED -> no imem writes, counters=0, o_hart_rst high for RST_HOLD cycles, then RUN.
REQ-040 i_rst asserted after 3 bytes accepted -> no imem write; a subsequent 4-byte stream writes addr RESET_ADDR.
